// File: rtl/core_wback_pkg.sv
// Writeback-stage types: channel indices and the per-channel result payload.
package core_wback_pkg;
  localparam int WB_CH_ALU    = 0;
  localparam int WB_CH_MULDIV = 1;

  // Payload carries data at the widest supported XLEN; narrower cores use the low bits.
  localparam int WB_DATA_MAX = 64;

  typedef struct packed {
    rv::regaddr_t           rd;
    logic [WB_DATA_MAX-1:0] wdata;
    logic                   wen;
  } wb_ch_t;
endpackage

// File: rtl/rv_pkg.sv
// Shared RISC-V core types used across pipeline stages.
package rv;
  typedef logic [4:0] regaddr_t;
endpackage

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; pointer moves past the winner.
module core_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int c;
    c        = 0;
    gnt_o    = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < N; k++) begin
      c = int'(rr_ptr_q) + k;
      if (c >= N) c = c - N;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    // Explicit compare keeps the wrap correct when N is not a power of two.
    if (en_i && vld_o)
      rr_ptr_d = (int'(idx_o) == N - 1) ? '0 : IW'(int'(idx_o) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/core_wback_arb.sv
// Multi-channel writeback: round-robin pick of one result per cycle, one registered RF write stage.
// Optional retired-instruction counter enabled by macro CORE_WBACK_INSTRET_EN.
module core_wback_arb
  import core_wback_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int XLEN = 32,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*5-1:0]  ch_rd,
  input  logic [NCH*XLEN-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_wen,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              retire_valid,
  output logic [CHW-1:0]    retire_ch,
  output logic [63:0]       instret
);
  logic [NCH-1:0] gnt;
  logic [CHW-1:0] gidx;
  logic           any_gnt;
  wb_ch_t         sel;

  logic              rf_wen_q, retire_valid_q;
  rv::regaddr_t      rf_waddr_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic [CHW-1:0]    retire_ch_q;

  core_rr_arbiter #(.N(NCH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (ch_valid & {NCH{~rst}}),
    .en_i  (~rst),
    .gnt_o (gnt),
    .idx_o (gidx),
    .vld_o (any_gnt)
  );

  assign ch_ready = gnt;

  always_comb begin
    sel       = '0;
    sel.rd    = ch_rd[int'(gidx)*5 +: 5];
    sel.wdata = WB_DATA_MAX'(ch_wdata[int'(gidx)*XLEN +: XLEN]);
    sel.wen   = ch_wen[gidx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q       <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_ch_q    <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
    end else begin
      rf_wen_q       <= any_gnt && sel.wen && (sel.rd != '0);
      retire_valid_q <= any_gnt;
      if (any_gnt) begin
        rf_waddr_q  <= sel.rd;
        rf_wdata_q  <= sel.wdata[XLEN-1:0];
        retire_ch_q <= gidx;
      end
    end
  end

  // A staged write is dropped as soon as reset rises, not one cycle later.
  assign rf_wen       = rf_wen_q & ~rst;
  assign retire_valid = retire_valid_q & ~rst;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_ch    = retire_ch_q;

`ifdef CORE_WBACK_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)          instret_q <= '0;
    else if (any_gnt) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_core_wback_arb.sv
// Directed bench for core_wback_arb: NCH=2 vector table plus reset and NCH=3 wrap sequences.
module tb_core_wback_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // NCH=2 instance
  logic [1:0]  v2, rdy2, wen2;
  logic [9:0]  rd2;
  logic [63:0] wd2;
  logic        fwen2, rv2;
  logic [4:0]  waddr2;
  logic [31:0] wdata2;
  logic [0:0]  rch2;
  logic [63:0] instret2;

  core_wback_arb #(.NCH(2), .XLEN(32)) u2 (
    .clk(clk), .rst(rst), .ch_valid(v2), .ch_ready(rdy2), .ch_rd(rd2),
    .ch_wdata(wd2), .ch_wen(wen2), .rf_wen(fwen2), .rf_waddr(waddr2),
    .rf_wdata(wdata2), .retire_valid(rv2), .retire_ch(rch2), .instret(instret2)
  );

  // NCH=3 instance
  logic [2:0]  v3, rdy3, wen3;
  logic [14:0] rd3;
  logic [95:0] wd3;
  logic        fwen3, rv3;
  logic [4:0]  waddr3;
  logic [31:0] wdata3;
  logic [1:0]  rch3;
  logic [63:0] instret3;

  core_wback_arb #(.NCH(3), .XLEN(32)) u3 (
    .clk(clk), .rst(rst), .ch_valid(v3), .ch_ready(rdy3), .ch_rd(rd3),
    .ch_wdata(wd3), .ch_wen(wen3), .rf_wen(fwen3), .rf_waddr(waddr3),
    .rf_wdata(wdata3), .retire_valid(rv3), .retire_ch(rch3), .instret(instret3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  rd0, rd1;
    logic [31:0] wd0, wd1;
    logic [1:0]  wen;
    logic [1:0]  rdy;
    logic        fwen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic        rch;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [4:0] rd0, logic [4:0] rd1,
                              logic [31:0] wd0, logic [31:0] wd1, logic [1:0] wen,
                              logic [1:0] rdy, logic fwen, logic [4:0] waddr,
                              logic [31:0] wdata, logic rv, logic rch);
    vec_t t;
    t.v = v; t.rd0 = rd0; t.rd1 = rd1; t.wd0 = wd0; t.wd1 = wd1; t.wen = wen;
    t.rdy = rdy; t.fwen = fwen; t.waddr = waddr; t.wdata = wdata; t.rv = rv; t.rch = rch;
    return t;
  endfunction

  vec_t tbl[11];

  task automatic drive2(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] w);
    v2 = v; rd2 = {r1, r0}; wd2 = {d1, d0}; wen2 = w;
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] exp_rdy, input logic [1:0] exp_rch,
                       input logic [31:0] exp_data, input string tag);
    @(negedge clk);
    v3 = v;
    #1 chk({tag, " ready3"}, 64'(rdy3), 64'(exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " retire_ch3"}, 64'(rch3), 64'(exp_rch));
    chk({tag, " wdata3"}, 64'(wdata3), 64'(exp_data));
    chk({tag, " retire_valid3"}, 64'(rv3), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_cnt;
    rst = 1'b1;
    drive2(2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b11);
    v3 = '0; wen3 = 3'b111;
    rd3 = {5'd12, 5'd11, 5'd10};
    wd3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    repeat (3) @(posedge clk);
    #1;
    chk("ready while rst", 64'(rdy2), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive2(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("reset rf_wen", 64'(fwen2), 64'd0);
    chk("reset retire_valid", 64'(rv2), 64'd0);
    chk("reset retire_ch", 64'(rch2), 64'd0);
    chk("reset rf_waddr", 64'(waddr2), 64'd0);
    chk("reset rf_wdata", 64'(wdata2), 64'd0);
    chk("reset instret", instret2, 64'd0);

    tbl[0]  = mk(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,   2'b11, 2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[1]  = mk(2'b11, 5'd1, 5'd2, 32'hA0,       32'hB1,  2'b11, 2'b10, 1'b1, 5'd2, 32'hB1,       1'b1, 1'b1);
    tbl[2]  = mk(2'b11, 5'd1, 5'd2, 32'hA0,       32'hB2,  2'b11, 2'b01, 1'b1, 5'd1, 32'hA0,       1'b1, 1'b0);
    tbl[3]  = mk(2'b11, 5'd1, 5'd2, 32'hA3,       32'hB2,  2'b11, 2'b10, 1'b1, 5'd2, 32'hB2,       1'b1, 1'b1);
    tbl[4]  = mk(2'b11, 5'd1, 5'd2, 32'hA3,       32'hB4,  2'b11, 2'b01, 1'b1, 5'd1, 32'hA3,       1'b1, 1'b0);
    tbl[5]  = mk(2'b10, 5'd0, 5'd0, 32'h0,        32'hC0,  2'b11, 2'b10, 1'b0, 5'd0, 32'hC0,       1'b1, 1'b1);
    tbl[6]  = mk(2'b01, 5'd7, 5'd0, 32'hD7,       32'h0,   2'b10, 2'b01, 1'b0, 5'd7, 32'hD7,       1'b1, 1'b0);
    tbl[7]  = mk(2'b00, 5'd0, 5'd0, 32'h0,        32'h0,   2'b00, 2'b00, 1'b0, 5'd7, 32'hD7,       1'b0, 1'b0);
    tbl[8]  = mk(2'b01, 5'd3, 5'd0, 32'hE3,       32'h0,   2'b11, 2'b01, 1'b1, 5'd3, 32'hE3,       1'b1, 1'b0);
    tbl[9]  = mk(2'b11, 5'd4, 5'd6, 32'hF4,       32'hF6,  2'b11, 2'b10, 1'b1, 5'd6, 32'hF6,       1'b1, 1'b1);
    tbl[10] = mk(2'b01, 5'd4, 5'd0, 32'hF4,       32'h0,   2'b11, 2'b01, 1'b1, 5'd4, 32'hF4,       1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive2(tbl[i].v, tbl[i].rd0, tbl[i].rd1, tbl[i].wd0, tbl[i].wd1, tbl[i].wen);
      #1 chk($sformatf("v%0d ch_ready", i), 64'(rdy2), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_wen", i), 64'(fwen2), 64'(tbl[i].fwen));
      chk($sformatf("v%0d rf_waddr", i), 64'(waddr2), 64'(tbl[i].waddr));
      chk($sformatf("v%0d rf_wdata", i), 64'(wdata2), 64'(tbl[i].wdata));
      chk($sformatf("v%0d retire_valid", i), 64'(rv2), 64'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("v%0d retire_ch", i), 64'(rch2), 64'(tbl[i].rch));
    end
`ifdef CORE_WBACK_INSTRET_EN
    exp_cnt = 64'd10;
`else
    exp_cnt = 64'd0;
`endif
    chk("instret after table", instret2, exp_cnt);

    // Reset right after a grant: the staged write must never show.
    @(negedge clk);
    drive2(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst N+1 rf_wen", 64'(fwen2), 64'd0);
    chk("rst N+1 retire_valid", 64'(rv2), 64'd0);
    chk("rst N+1 ch_ready", 64'(rdy2), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive2(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("rst N+2 rf_wen", 64'(fwen2), 64'd0);
    chk("rst N+2 retire_valid", 64'(rv2), 64'd0);
    chk("rst N+2 rf_wdata", 64'(wdata2), 64'd0);
    chk("rst N+2 instret", instret2, 64'd0);

    // Pointer restarts at 0 after reset; three retirements follow.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive2(2'b11, 5'd1, 5'd2, 32'h100 + 32'(i), 32'h200 + 32'(i), 2'b11);
      #1 chk($sformatf("post-rst %0d ch_ready", i), 64'(rdy2), (i % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1;
      chk($sformatf("post-rst %0d retire_ch", i), 64'(rch2), (i % 2 == 0) ? 64'd0 : 64'd1);
    end
`ifdef CORE_WBACK_INSTRET_EN
    exp_cnt = 64'd3;
`else
    exp_cnt = 64'd0;
`endif
    chk("instret after 3 retires", instret2, exp_cnt);
    @(negedge clk);
    drive2(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);

    // NCH=3 wrap: move ptr to 2, then {ch0,ch2} valid.
    step3(3'b010, 3'b010, 2'd1, 32'h3333_0001, "w3 a");
    step3(3'b101, 3'b100, 2'd2, 32'h3333_0002, "w3 b");
    step3(3'b001, 3'b001, 2'd0, 32'h3333_0000, "w3 c");
    step3(3'b111, 3'b010, 2'd1, 32'h3333_0001, "w3 d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/core_wback_arb.md
Name: core_wback_arb

Overview:
- Multi-channel writeback stage for the core.
- Accepts completed results from NCH functional-unit channels (ALU/load, mul/div, CSR, ...) over valid/ready handshakes.
- Selects one result per cycle with round-robin arbitration.
- Drives the register-file write port through one registered stage; also reports retirement and exposes the staged write for forwarding.

Parameters:
- NCH, 2, number of writeback channels (1..8).
- XLEN, 32, data width of results and register-file write data.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-high.
- ch_valid  input  NCH  per-channel result valid.
- ch_ready  output  NCH  per-channel accept; one-hot or zero.
- ch_rd  input  NCH*5  per-channel destination register (rv::regaddr_t each).
- ch_wdata  input  NCH*XLEN  per-channel result data.
- ch_wen  input  NCH  per-channel "writes a register"; 0 means retire only (store/branch).
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  XLEN  register-file write data.
- retire_valid  output  1  one instruction retired this cycle.
- retire_ch  output  $clog2(NCH) (min 1)  channel that retired.
- instret  output  64  retired-instruction count (see Optional Feature).

Behaviour:
- Handshake:
  - Transfer on channel i when ch_valid[i] && ch_ready[i].
  - ch_ready depends combinationally on ch_valid and the arbiter pointer.
  - Producers must hold valid and payload stable until accepted; the block must not depend on ch_ready → ch_valid paths.
- Arbitration:
  - Pointer rr_ptr, reset 0.
  - Grant the first valid channel scanning rr_ptr, rr_ptr+1, ... modulo NCH.
  - After a grant to channel g, rr_ptr <= (g+1) mod NCH; wrap is correct for non-power-of-two NCH.
  - If no channel is valid, rr_ptr holds and ch_ready = 0.
  - NCH=1: always grant channel 0, rr_ptr stays 0.
- Output stage (registered, latency 1 cycle from handshake):
  - rf_wen <= grant && ch_wen[g] && (ch_rd[g] != 0); x0 writes are suppressed but still retire.
  - rf_waddr <= ch_rd[g] and rf_wdata <= ch_wdata[g], loaded on any grant.
  - Otherwise rf_wen <= 0; address and data hold their last value.
  - retire_valid <= grant; retire_ch <= g.
- Throughput: one transfer per cycle sustained; the stage never stalls, and the register file always accepts.
- Reset:
  - rf_wen, retire_valid, retire_ch, rf_waddr, rf_wdata, rr_ptr and instret all reset to 0.
  - Reset asserted mid-transfer drops the staged write; no write appears in the cycle after reset.
  - ch_ready is 0 while rst is high.
- Same-rd ordering between channels is the issue stage's responsibility. This block writes strictly in grant order.

Optional Feature:
- Macro CORE_WBACK_INSTRET_EN.
- Defined:
  - 64-bit counter increments by 1 on every cycle where retire_valid would be set, including x0 and ch_wen=0 retirements.
  - instret reflects the registered count, i.e. it includes retirements up to the previous cycle.
  - Wraps from 2^64-1 to 0.
- Not defined: no counter logic; instret is tied to 0.

Decomposition:
- Package core_wback_pkg:
  - Channel index constants: WB_CH_ALU=0, WB_CH_MULDIV=1.
  - Typedef wb_ch_t for the {rd, wdata, wen} payload.
  - Reuse rv::regaddr_t for register addresses.
- Sub-module core_rr_arbiter:
  - Parameter N; inputs req[N], update enable; outputs one-hot grant[N] and encoded index.
  - Holds rr_ptr.
  - Reusable for other arbiters in the core.

Test Plan:
- Single channel: ch0 valid, rd=5, wdata=0xDEADBEEF, wen=1 → ch_ready[0]=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, retire_valid=1, retire_ch=0.
- Contention fairness, NCH=2, both channels continuously valid for 4 cycles → grants alternate 0,1,0,1; each channel's value appears on rf_wdata exactly once per two cycles.
- x0 and no-write:
  - ch1 rd=0, wen=1 → rf_wen=0, retire_valid=1, retire_ch=1.
  - ch0 wen=0, rd=7 → rf_wen=0, retire_valid=1.
- Backpressure hold: ch0 and ch1 valid after a grant to ch0 → ch0 sees ready=0, holds payload, and is accepted the following cycle with its payload unchanged on rf_wdata.
- Wrap, NCH=3, ptr=2, valid={ch0,ch2} → grant ch2, ptr becomes 0; next grant ch0, ptr becomes 1.
- Reset mid-operation: grant to ch0 in cycle N, rst=1 in N+1 → rf_wen=0 and retire_valid=0 in N+1 and N+2. With CORE_WBACK_INSTRET_EN, instret=0 after reset, then reads 3 after three retirements.
